// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into SEG-bit
// segments, one per stage, with skew/deskew registers and a valid/ready handshake.
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int STAGES = WIDTH / SEG;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is A + ~B + !borrow; sub_i is folded away before stage 0.
    assign b_eff   = sub_i ? ~b_i : b_i;
    assign c0      = sub_i ? ~cin_i : cin_i;
    assign ready_o = !valid_o || ready_i;
    assign en      = ready_o;

    for (genvar k = 0; k < STAGES; k++) begin : stage
        logic             in_vld;
        logic             in_carry;
        logic [WIDTH-1:0] in_data;
        logic [WIDTH-1:0] in_b;
        logic [SEG:0]     seg_sum;

        logic             vld_q, vld_d;
        logic             carry_q, carry_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic [WIDTH-1:0] b_q, b_d;

        // data holds finished result segments below this stage and unconsumed A above it.
        if (k == 0) begin : g_first
            assign in_vld   = valid_i;
            assign in_carry = c0;
            assign in_data  = a_i;
            assign in_b     = b_eff;
        end else begin : g_next
            assign in_vld   = stage[k-1].vld_q;
            assign in_carry = stage[k-1].carry_q;
            assign in_data  = stage[k-1].data_q;
            assign in_b     = stage[k-1].b_q;
        end

        assign seg_sum = {1'b0, in_data[k*SEG +: SEG]}
                       + {1'b0, in_b[k*SEG +: SEG]}
                       + {{SEG{1'b0}}, in_carry};

        always_comb begin
            vld_d   = vld_q;
            carry_d = carry_q;
            data_d  = data_q;
            b_d     = b_q;
            if (en) begin
                vld_d                   = in_vld;
                carry_d                 = seg_sum[SEG];
                data_d                  = in_data;
                data_d[k*SEG +: SEG]    = seg_sum[SEG-1:0];
                b_d                     = in_b;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                data_q  <= '0;
                b_q     <= '0;
            end else begin
                vld_q   <= vld_d;
                carry_q <= carry_d;
                data_q  <= data_d;
                b_q     <= b_d;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_q, ovf_d;
            logic msb_cin;

            // Carry into the MSB recovered from the MSB's own sum bit.
            assign msb_cin = in_data[WIDTH-1] ^ in_b[WIDTH-1] ^ seg_sum[SEG-1];

            always_comb begin
                ovf_d = ovf_q;
                if (en) begin
                    ovf_d = msb_cin ^ seg_sum[SEG];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    // The final stage's operand skew register has no consumer.
    logic unused_last_b;
    assign unused_last_b = ^stage[STAGES-1].b_q;

    assign valid_o = stage[STAGES-1].vld_q;
    assign sum_o   = stage[STAGES-1].data_q;
    assign cout_o  = stage[STAGES-1].carry_q;
    assign ovf_o   = stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: three instances (32/8, 8/8, 16/4) share one stimulus stream,
// each checked by its own scoreboard against an arithmetic reference model.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cin_i;
    logic        sub_i;

    logic        ready_o0, valid_o0, cout_o0, ovf_o0;
    logic [31:0] sum_o0;
    logic        ready_o1, valid_o1, cout_o1, ovf_o1;
    logic [7:0]  sum_o1;
    logic        ready_o2, valid_o2, cout_o2, ovf_o2;
    logic [15:0] sum_o2;

    int total = 0;
    int bad   = 0;
    int acc0 = 0, acc1 = 0, acc2 = 0;
    int pop0 = 0, pop1 = 0, pop2 = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(32), .SEG(8)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o0),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
        .valid_o(valid_o0), .ready_i(ready_i), .sum_o(sum_o0),
        .cout_o(cout_o0), .ovf_o(ovf_o0)
    );

    adder_pipe #(.WIDTH(8), .SEG(8)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o1),
        .a_i(a_i[7:0]), .b_i(b_i[7:0]), .cin_i(cin_i), .sub_i(sub_i),
        .valid_o(valid_o1), .ready_i(ready_i), .sum_o(sum_o1),
        .cout_o(cout_o1), .ovf_o(ovf_o1)
    );

    adder_pipe #(.WIDTH(16), .SEG(4)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o2),
        .a_i(a_i[15:0]), .b_i(b_i[15:0]), .cin_i(cin_i), .sub_i(sub_i),
        .valid_o(valid_o2), .ready_i(ready_i), .sum_o(sum_o2),
        .cout_o(cout_o2), .ovf_o(ovf_o2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s, input logic r);
        valid_i = v;
        a_i     = a;
        b_i     = b;
        cin_i   = c;
        sub_i   = s;
        ready_i = r;
    endtask

    // Packs {ovf, cout, sum} the same way for model and DUT.
    function automatic logic [63:0] pack(input logic ovf, input logic cout, input logic [31:0] sum);
        return {30'b0, ovf, cout, sum};
    endfunction

    // Plain integer arithmetic: sum modulo 2^w, unsigned carry/no-borrow, signed range overflow.
    function automatic logic [63:0] refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                             input logic cin, input logic sub);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = {32'b0, a} & mask;
        longint ub   = {32'b0, b} & mask;
        longint c    = cin ? 1 : 0;
        longint sa   = (ua >= half) ? ua - 2 * half : ua;
        longint sb   = (ub >= half) ? ub - 2 * half : ub;
        longint sum, ideal;
        logic   cout, ovf;
        if (sub) begin
            ideal = sa - sb - c;
            sum   = (ua - ub - c) & mask;
            cout  = (ua >= ub + c);
        end else begin
            ideal = sa + sb + c;
            sum   = (ua + ub + c) & mask;
            cout  = (((ua + ub + c) >> w) & 1) != 0;
        end
        ovf = (ideal >= half) || (ideal < -half);
        return pack(ovf, cout, sum[31:0]);
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboards sample at the falling edge, i.e. the handshake the next rising edge will see.
    always @(negedge clk) begin
        if (rst_i) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (valid_o0 && ready_i) begin
                if (q0.size() == 0) checkOutput("sb0_extra", 1, 0);
                else begin
                    checkOutput("sb0_result", pack(ovf_o0, cout_o0, sum_o0), q0.pop_front());
                    pop0++;
                end
            end
            if (valid_o1 && ready_i) begin
                if (q1.size() == 0) checkOutput("sb1_extra", 1, 0);
                else begin
                    checkOutput("sb1_result", pack(ovf_o1, cout_o1, {24'b0, sum_o1}), q1.pop_front());
                    pop1++;
                end
            end
            if (valid_o2 && ready_i) begin
                if (q2.size() == 0) checkOutput("sb2_extra", 1, 0);
                else begin
                    checkOutput("sb2_result", pack(ovf_o2, cout_o2, {16'b0, sum_o2}), q2.pop_front());
                    pop2++;
                end
            end
            if (valid_i && ready_o0) begin
                q0.push_back(refModel(32, a_i, b_i, cin_i, sub_i));
                acc0++;
            end
            if (valid_i && ready_o1) begin
                q1.push_back(refModel(8, a_i, b_i, cin_i, sub_i));
                acc1++;
            end
            if (valid_i && ready_o2) begin
                q2.push_back(refModel(16, a_i, b_i, cin_i, sub_i));
                acc2++;
            end
        end
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_out0"}, pack(ovf_o0, cout_o0, sum_o0), 64'd0);
        checkOutput({tag, "_valid"}, {61'b0, valid_o0, valid_o1, valid_o2}, 64'd0);
        checkOutput({tag, "_ready"}, {61'b0, ready_o0, ready_o1, ready_o2}, 64'd7);
    endtask

    // One isolated op; measures latency of every instance and checks the 32-bit result.
    task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic s, input logic [31:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        int          n0 = 0, n1 = 0, n2 = 0;
        logic [63:0] seen = '0;
        @(posedge clk); #1;
        applyStimulus(1'b1, a, b, c, s, 1'b1);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e == 1) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            if (valid_o0 && n0 == 0) begin
                n0   = e;
                seen = pack(ovf_o0, cout_o0, sum_o0);
            end
            if (valid_o1 && n1 == 0) n1 = e;
            if (valid_o2 && n2 == 0) n2 = e;
        end
        checkOutput({tag, "_lat32"}, n0, 4);
        checkOutput({tag, "_lat8"}, n1, 1);
        checkOutput({tag, "_lat16"}, n2, 4);
        checkOutput({tag, "_res32"}, seen, pack(exp_ovf, exp_cout, exp_sum));
    endtask

    initial begin
        logic [31:0] vpat;
        logic [63:0] snap;
        int          first, count, last, stray;

        rst_i = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        checkIdle("reset");

        runDirected("all_ones_p1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        runDirected("max_pos_p1",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        runDirected("min_neg_m1",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        runDirected("five_m7",     32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runDirected("ten_m3_brw",  32'd10,        32'd3,         1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);

        $display("[TB] back-to-back stream");
        vpat = '0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (e > 0) vpat[e] = valid_o0;
            if (e < 16) applyStimulus(1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                                      1'($urandom_range(0, 1)), 1'b1);
            else applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        first = -1; count = 0; last = -1;
        for (int i = 0; i < 30; i++) begin
            if (vpat[i]) begin
                if (first < 0) first = i;
                last = i;
                count++;
            end
        end
        checkOutput("b2b_first", first, 4);
        checkOutput("b2b_count", count, 16);
        checkOutput("b2b_contig", last - first + 1, 16);

        $display("[TB] stall with full pipeline");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1);
        end
        @(posedge clk); #1;
        applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b0, 1'b0);
        snap = pack(ovf_o0, cout_o0, sum_o0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b0);
            checkOutput("stall_ready", {61'b0, ready_o0, ready_o1, ready_o2}, 64'd0);
            checkOutput("stall_valid", {63'b0, valid_o0}, 64'd1);
            checkOutput("stall_hold", pack(ovf_o0, cout_o0, sum_o0), snap);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("stall_drain0", q0.size(), 0);
        checkOutput("stall_count0", pop0, acc0);

        $display("[TB] random handshake traffic");
        for (int cyc = 0; cyc < 20000 && acc0 < 1000; cyc++) begin
            @(posedge clk); #1;
            applyStimulus($urandom_range(0, 3) != 0, randOperand(), randOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
        end
        checkOutput("rand_accepts", {63'b0, acc0 >= 1000}, 64'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rand_drain0", q0.size(), 0);
        checkOutput("rand_drain1", q1.size(), 0);
        checkOutput("rand_drain2", q2.size(), 0);
        checkOutput("rand_count0", pop0, acc0);
        checkOutput("rand_count1", pop1, acc1);
        checkOutput("rand_count2", pop2, acc2);

        $display("[TB] reset with ops in flight");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        checkIdle("midreset");
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid_o0 || valid_o1 || valid_o2) stray++;
        end
        checkOutput("midreset_stale", stray, 0);

        runDirected("post_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
